// File: rtl/cnn_bn_relu_1x1_pkg.sv
// Shared word format, FSM encoding and saturation bounds for the 1x1 batch-norm/ReLU stage.
// Pixels, scales and biases all use the same signed Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS format.
package cnn_bn_relu_1x1_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 8;
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int ACC_WIDTH  = PROD_WIDTH + 2;

    typedef logic signed [DATA_WIDTH-1:0] word_t;
    typedef logic signed [PROD_WIDTH-1:0] prod_t;
    typedef logic signed [ACC_WIDTH-1:0]  acc_t;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam word_t SAT_MAX    = word_t'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam word_t SAT_MIN    = word_t'({1'b1, {(DATA_WIDTH-1){1'b0}}});
    localparam acc_t  ROUND_HALF = acc_t'(1) <<< (FRAC_BITS - 1);

    // Bias add, round-half-up, arithmetic rescale, saturate and optional rectify.
    function automatic word_t bn_finish(input prod_t prod, input word_t bias, input logic relu_en);
        acc_t  sum;
        acc_t  shifted;
        word_t res;
        sum     = acc_t'(prod) + (acc_t'(bias) <<< FRAC_BITS) + ROUND_HALF;
        shifted = sum >>> FRAC_BITS;
        if (shifted > acc_t'(SAT_MAX)) begin
            res = SAT_MAX;
        end else if (shifted < acc_t'(SAT_MIN)) begin
            res = SAT_MIN;
        end else begin
            res = word_t'(shifted[DATA_WIDTH-1:0]);
        end
        if (relu_en && res[DATA_WIDTH-1]) begin
            res = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/cnn_bn_relu_1x1_coef_ram.sv
// Per-channel coefficient store: one row per channel holding {bias, scale}.
// Loads arrive one word at a time, so the write port selects a half-row lane.
module cnn_bn_coef_ram
    import cnn_bn_relu_1x1_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic                  wr_lane,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_scale,
    output logic [DATA_WIDTH-1:0] rd_bias
);

    logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [2*DATA_WIDTH-1:0] rd_data_q;

    // NOTE: the array has no reset so it maps onto block RAM; its contents are
    // only trusted after a full coefficient load, which the control FSM enforces.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_lane) begin
                mem_q[wr_addr][2*DATA_WIDTH-1:DATA_WIDTH] <= wr_data;
            end else begin
                mem_q[wr_addr][DATA_WIDTH-1:0] <= wr_data;
            end
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_scale = rd_data_q[DATA_WIDTH-1:0];
    assign rd_bias  = rd_data_q[2*DATA_WIDTH-1:DATA_WIDTH];

endmodule

// File: rtl/cnn_bn_relu_1x1.sv
// Folded batch-norm (scale/bias) plus optional ReLU on the channel-interleaved conv stream.
// Three-stage pipeline: coefficient read, multiply, bias/round/saturate/rectify.
module cnn_bn_relu_1x1
    import cnn_bn_relu_1x1_pkg::*;
#(
    parameter int CHANNEL_NUM = 256,
    parameter int IMAGE_SIZE  = 306 * 306,
    parameter bit RELU_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  valid_weight_in,
    input  logic [DATA_WIDTH-1:0] weight_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  coef_ready,
    output logic                  frame_done,
    output logic                  drop_err
);

    localparam int LOAD_W = $clog2(2 * CHANNEL_NUM);
    localparam int CH_W   = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam int PIX_W  = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;

    localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(2 * CHANNEL_NUM - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNEL_NUM - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(IMAGE_SIZE - 1);

    state_e              state_q;
    logic [LOAD_W-1:0]   load_cnt_q;
    logic [CH_W-1:0]     ch_q;
    logic [PIX_W-1:0]    pix_q;
    logic                coef_ready_q;
    logic                drop_err_q;

    logic                px_accept;
    logic                px_last;
    logic [LOAD_W-1:0]   coef_idx;

    // A coefficient word always wins the cycle; a pixel beside it is dropped.
    assign px_accept = valid_in && (state_q == ST_RUN) && !valid_weight_in;
    assign px_last   = (ch_q == CH_LAST) && (pix_q == PIX_LAST);
    assign coef_idx  = (state_q == ST_RUN) ? '0 : load_cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_LOAD;
            load_cnt_q   <= '0;
            ch_q         <= '0;
            pix_q        <= '0;
            coef_ready_q <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            if (valid_in && !px_accept) begin
                drop_err_q <= 1'b1;
            end
            case (state_q)
                ST_LOAD: begin
                    if (valid_weight_in) begin
                        if (load_cnt_q == LOAD_LAST) begin
                            state_q      <= ST_RUN;
                            load_cnt_q   <= '0;
                            coef_ready_q <= 1'b1;
                        end else begin
                            load_cnt_q <= load_cnt_q + LOAD_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (valid_weight_in) begin
                        // This word is already coefficient 0; the next one is index 1.
                        state_q      <= ST_LOAD;
                        load_cnt_q   <= LOAD_W'(1);
                        ch_q         <= '0;
                        pix_q        <= '0;
                        coef_ready_q <= 1'b0;
                    end else if (valid_in) begin
                        if (ch_q == CH_LAST) begin
                            ch_q  <= '0;
                            pix_q <= (pix_q == PIX_LAST) ? '0 : pix_q + PIX_W'(1);
                        end else begin
                            ch_q <= ch_q + CH_W'(1);
                        end
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    logic [DATA_WIDTH-1:0] rd_scale;
    logic [DATA_WIDTH-1:0] rd_bias;

    cnn_bn_coef_ram #(
        .DEPTH (CHANNEL_NUM),
        .AW    (CH_W)
    ) u_coef_ram (
        .clk      (clk),
        .wr_en    (valid_weight_in),
        .wr_addr  (coef_idx[LOAD_W-1:1]),
        .wr_lane  (coef_idx[0]),
        .wr_data  (weight_in),
        .rd_en    (px_accept),
        .rd_addr  (ch_q),
        .rd_scale (rd_scale),
        .rd_bias  (rd_bias)
    );

    logic  valid_s1_q, valid_s1_d;
    logic  last_s1_q,  last_s1_d;
    word_t pxl_s1_q,   pxl_s1_d;
    logic  valid_s2_q, valid_s2_d;
    logic  last_s2_q,  last_s2_d;
    prod_t prod_s2_q,  prod_s2_d;
    word_t bias_s2_q,  bias_s2_d;
    word_t pxl_out_q,  pxl_out_d;
    logic  valid_out_q, valid_out_d;
    logic  frame_done_q, frame_done_d;

    // NOTE: every always_comb output gets its default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        valid_s1_d   = px_accept;
        last_s1_d    = px_accept && px_last;
        pxl_s1_d     = pxl_s1_q;
        valid_s2_d   = valid_s1_q;
        last_s2_d    = last_s1_q;
        prod_s2_d    = prod_s2_q;
        bias_s2_d    = bias_s2_q;
        valid_out_d  = valid_s2_q;
        frame_done_d = last_s2_q;
        pxl_out_d    = pxl_out_q;
        if (px_accept) begin
            pxl_s1_d = word_t'(pxl_in);
        end
        if (valid_s1_q) begin
            prod_s2_d = prod_t'(pxl_s1_q) * prod_t'(word_t'(rd_scale));
            bias_s2_d = word_t'(rd_bias);
        end
        if (valid_s2_q) begin
            pxl_out_d = bn_finish(prod_s2_q, bias_s2_q, RELU_EN);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_s1_q   <= 1'b0;
            last_s1_q    <= 1'b0;
            pxl_s1_q     <= '0;
            valid_s2_q   <= 1'b0;
            last_s2_q    <= 1'b0;
            prod_s2_q    <= '0;
            bias_s2_q    <= '0;
            pxl_out_q    <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            valid_s1_q   <= valid_s1_d;
            last_s1_q    <= last_s1_d;
            pxl_s1_q     <= pxl_s1_d;
            valid_s2_q   <= valid_s2_d;
            last_s2_q    <= last_s2_d;
            prod_s2_q    <= prod_s2_d;
            bias_s2_q    <= bias_s2_d;
            pxl_out_q    <= pxl_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pxl_out    = pxl_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;
    assign coef_ready = coef_ready_q;
    assign drop_err   = drop_err_q;

endmodule
